// File: rtl/sched_pkg.sv
// sched_pkg: shared types and default widths for the ALU issue scheduler.
//   sched_instr_t - one queued ALU instruction (op, sources, imm select, imm, dest)
//   fu_state_e    - per-FU occupancy state
package sched_pkg;

    localparam int SCHED_SIZE       = 32;
    localparam int SCHED_REG_NUM    = 8;
    localparam int SCHED_ALUOP_BITS = 3;
    localparam int SCHED_RW         = $clog2(SCHED_REG_NUM);

    typedef struct packed {
        logic [SCHED_ALUOP_BITS-1:0] ALUOp;
        logic [SCHED_RW-1:0]         src_reg1;
        logic [SCHED_RW-1:0]         src_reg2;
        logic                        use_imm;
        logic [SCHED_SIZE-1:0]       imm;
        logic [SCHED_RW-1:0]         dest_reg;
    } sched_instr_t;

    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: synchronous FIFO of sched_instr_t with occupancy count.
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_data (ignored when full, even if popping)
//   pop         - advance read pointer (ignored when empty)
//   pop_data    - current head entry (valid when !empty)
//   count       - occupancy, 0..DEPTH
//   full, empty - occupancy flags
module sched_fifo
    import sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  sched_instr_t push_data,
    input  logic         pop,
    output sched_instr_t pop_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    sched_instr_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: in-order issue of queued ALU instructions to NUM_FU
// functional units sharing one register file, with a destination scoreboard.
//   in_*        - instruction offer (in_valid/in_ready handshake)
//   fu_issue    - registered one-cycle issue pulse per FU, payload on fu_*
//   fu_comp     - per-FU completion pulse; frees that FU and its destination
//   busy_regs   - scoreboard, bit r set while a write to r is pending
//   q_count     - queue occupancy; stall - head waiting this cycle
// Optional macro SCHED_COMP_BYPASS_EN: hazard/FU checks see this cycle's
// fu_comp clears, letting a waiting head issue in the same cycle.
module alu_issue_scheduler
    import sched_pkg::*;
#(
    parameter  int SIZE       = SCHED_SIZE,
    parameter  int REG_NUM    = SCHED_REG_NUM,
    parameter  int ALUOP_BITS = SCHED_ALUOP_BITS,
    parameter  int NUM_FU     = 2,
    parameter  int QDEPTH     = 4,
    localparam int RW         = $clog2(REG_NUM),
    localparam int CW         = $clog2(QDEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ALUOP_BITS-1:0]          in_ALUOp,
    input  logic [RW-1:0]                  in_src_reg1,
    input  logic [RW-1:0]                  in_src_reg2,
    input  logic                           in_use_imm,
    input  logic [SIZE-1:0]                in_imm,
    input  logic [RW-1:0]                  in_dest_reg,
    output logic [NUM_FU-1:0]              fu_issue,
    output logic [NUM_FU*ALUOP_BITS-1:0]   fu_ALUOp,
    output logic [NUM_FU*RW-1:0]           fu_src_reg1,
    output logic [NUM_FU*RW-1:0]           fu_src_reg2,
    output logic [NUM_FU-1:0]              fu_use_imm,
    output logic [NUM_FU*SIZE-1:0]         fu_imm,
    output logic [NUM_FU*RW-1:0]           fu_dest_reg,
    input  logic [NUM_FU-1:0]              fu_comp,
    output logic [REG_NUM-1:0]             busy_regs,
    output logic [CW-1:0]                  q_count,
    output logic                           stall
);

    sched_instr_t      in_instr;
    sched_instr_t      head;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              issue;
    logic              haz_free;
    logic              found;

    fu_state_e         fu_state    [NUM_FU];
    fu_state_e         fu_state_nx [NUM_FU];
    logic [RW-1:0]     fu_tag      [NUM_FU];
    logic [NUM_FU-1:0] comp_ok;
    logic [NUM_FU-1:0] idle_chk;
    logic [NUM_FU-1:0] sel_oh;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] busy_chk;
    logic [REG_NUM-1:0] busy_nx;

    assign in_instr = '{ALUOp:    in_ALUOp,
                        src_reg1: in_src_reg1,
                        src_reg2: in_src_reg2,
                        use_imm:  in_use_imm,
                        imm:      in_imm,
                        dest_reg: in_dest_reg};

    // Full blocks the push even when the head pops in the same cycle.
    assign in_ready = !q_full;
    assign push     = in_valid && in_ready;

    sched_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(in_instr),
        .pop      (issue),
        .pop_data (head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_comb begin
        comp_ok  = '0;
        idle_chk = '0;
        clr_mask = '0;
        set_mask = '0;
        sel_oh   = '0;
        found    = 1'b0;

        // Completion only counts for an FU that actually holds work.
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            comp_ok[i] = fu_comp[i] && (fu_state[i] == FU_BUSY);
            if (comp_ok[i]) clr_mask[fu_tag[i]] = 1'b1;
        end

`ifdef SCHED_COMP_BYPASS_EN
        busy_chk = busy_regs & ~clr_mask;
        for (int unsigned i = 0; i < NUM_FU; i++)
            idle_chk[i] = (fu_state[i] == FU_IDLE) || comp_ok[i];
`else
        busy_chk = busy_regs;
        for (int unsigned i = 0; i < NUM_FU; i++)
            idle_chk[i] = (fu_state[i] == FU_IDLE);
`endif

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (idle_chk[i] && !found) begin
                sel_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end

        haz_free = !busy_chk[head.src_reg1]
                && (head.use_imm || !busy_chk[head.src_reg2])
                && !busy_chk[head.dest_reg];
        issue    = !q_empty && found && haz_free;
        stall    = !q_empty && !issue;

        if (issue) set_mask[head.dest_reg] = 1'b1;
        // A same-cycle set of a register being cleared must survive.
        busy_nx = (busy_regs & ~clr_mask) | set_mask;

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_state_nx[i] = fu_state[i];
            if (issue && sel_oh[i])  fu_state_nx[i] = FU_BUSY;
            else if (comp_ok[i])     fu_state_nx[i] = FU_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FU; i++) fu_state[i] <= FU_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) fu_state[i] <= fu_state_nx[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_regs   <= '0;
            fu_issue    <= '0;
            fu_ALUOp    <= '0;
            fu_src_reg1 <= '0;
            fu_src_reg2 <= '0;
            fu_use_imm  <= '0;
            fu_imm      <= '0;
            fu_dest_reg <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) fu_tag[i] <= '0;
        end else begin
            busy_regs <= busy_nx;
            fu_issue  <= issue ? sel_oh : '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (issue && sel_oh[i]) begin
                    fu_tag[i]                              <= head.dest_reg;
                    fu_ALUOp[i*ALUOP_BITS +: ALUOP_BITS]   <= head.ALUOp;
                    fu_src_reg1[i*RW +: RW]                <= head.src_reg1;
                    fu_src_reg2[i*RW +: RW]                <= head.src_reg2;
                    fu_use_imm[i]                          <= head.use_imm;
                    fu_imm[i*SIZE +: SIZE]                 <= head.imm;
                    fu_dest_reg[i*RW +: RW]                <= head.dest_reg;
                end
            end
        end
    end

endmodule
